ntt_bitrev_reorder: RTL and testbench

NTT_BITREV_REORDER -- requirements
Module: ntt_bitrev_reorder

---
 rtl/ntt_bitrev_reorder.sv | 178 +++++++++++++++++
 tb/tb_ntt_bitrev_reorder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bitrev_reorder.sv
// Two-bank ping-pong frame buffer that reorders NTT result words into bit-reversed order.
// Define NTT_REORDER_BITREV_EN for bit-reversed readout; when undefined, frames pass through in natural order.
module ntt_bitrev_reorder #(
  parameter int W = 32,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);

  localparam int LG = $clog2(N);
  localparam logic [LG-1:0] CNT_ZERO = {LG{1'b0}};
  localparam logic [LG-1:0] CNT_ONE  = {{(LG-1){1'b0}}, 1'b1};
  localparam logic [LG-1:0] CNT_LAST = {LG{1'b1}};

  typedef enum logic [1:0] {
    BANK_FREE     = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_st_t;

  function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] v);
    logic [LG-1:0] r;
    for (int i = 0; i < LG; i++) begin
      r[i] = v[LG-1-i];
    end
    return r;
  endfunction

  function automatic logic [LG-1:0] rd_addr(input logic [LG-1:0] idx);
`ifdef NTT_REORDER_BITREV_EN
    return bitrev(idx);
`else
    return idx;
`endif
  endfunction

  logic [W-1:0]  mem_r [0:2*N-1];
  bank_st_t      bank_st_r [0:1];
  bank_st_t      bank_st_nxt_s [0:1];
  logic          wr_sel_r, wr_sel_nxt_s;
  logic          rd_sel_r, rd_sel_nxt_s;
  logic [LG-1:0] wr_cnt_r, wr_cnt_nxt_s;
  logic [LG-1:0] rd_cnt_r, rd_cnt_nxt_s;
  logic          in_ready_r, in_ready_nxt_s;
  logic          out_valid_r, out_valid_nxt_s;
  logic          out_last_r, out_last_nxt_s;
  logic [W-1:0]  out_data_r, out_data_nxt_s;
  logic          wr_fire_s, wr_done_s;
  logic          ld_s, ld_bank_s;
  logic [LG-1:0] ld_idx_s;
  logic [W-1:0]  rd_data_s;

  // Next-state logic for bank states, counters, selects and the output stage.
  always_comb begin
    bank_st_nxt_s   = bank_st_r;
    wr_sel_nxt_s    = wr_sel_r;
    rd_sel_nxt_s    = rd_sel_r;
    wr_cnt_nxt_s    = wr_cnt_r;
    rd_cnt_nxt_s    = rd_cnt_r;
    out_valid_nxt_s = out_valid_r;
    out_last_nxt_s  = out_last_r;
    out_data_nxt_s  = out_data_r;
    ld_s            = 1'b0;
    ld_bank_s       = rd_sel_r;
    ld_idx_s        = rd_cnt_r;
    wr_fire_s       = in_valid && in_ready_r;
    wr_done_s       = wr_fire_s && (wr_cnt_r == CNT_LAST);

    if (wr_fire_s) begin
      wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
      if (wr_done_s) begin
        bank_st_nxt_s[wr_sel_r] = BANK_FULL;
        wr_sel_nxt_s            = ~wr_sel_r;
      end else begin
        bank_st_nxt_s[wr_sel_r] = BANK_FILLING;
      end
    end else begin
      wr_cnt_nxt_s = wr_cnt_r;
    end

    // The output register holds word rd_cnt of the read bank; ld_* selects the word loaded next.
    case (bank_st_r[rd_sel_r])
      BANK_FULL: begin
        bank_st_nxt_s[rd_sel_r] = BANK_DRAINING;
      end
      BANK_DRAINING: begin
        if (!out_valid_r) begin
          ld_s = 1'b1;
        end else if (out_ready) begin
          if (rd_cnt_r == CNT_LAST) begin
            bank_st_nxt_s[rd_sel_r] = BANK_FREE;
            rd_sel_nxt_s            = ~rd_sel_r;
            rd_cnt_nxt_s            = CNT_ZERO;
            // Hand straight over to the other bank, even one completing on this edge, so frames stay gap-free.
            if ((bank_st_r[~rd_sel_r] == BANK_FULL) || (wr_done_s && (wr_sel_r != rd_sel_r))) begin
              bank_st_nxt_s[~rd_sel_r] = BANK_DRAINING;
              ld_s      = 1'b1;
              ld_bank_s = ~rd_sel_r;
              ld_idx_s  = CNT_ZERO;
            end else begin
              ld_s = 1'b0;
            end
          end else begin
            rd_cnt_nxt_s = rd_cnt_r + CNT_ONE;
            ld_s         = 1'b1;
            ld_idx_s     = rd_cnt_r + CNT_ONE;
          end
        end else begin
          ld_s = 1'b0;
        end
      end
      default: begin
        ld_s = 1'b0;
      end
    endcase

    rd_data_s = mem_r[{ld_bank_s, rd_addr(ld_idx_s)}];

    if (!out_valid_r || out_ready) begin
      out_valid_nxt_s = ld_s;
      out_last_nxt_s  = ld_s && (ld_idx_s == CNT_LAST);
      out_data_nxt_s  = ld_s ? rd_data_s : out_data_r;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end

    in_ready_nxt_s = (bank_st_nxt_s[wr_sel_nxt_s] == BANK_FREE) ||
                     (bank_st_nxt_s[wr_sel_nxt_s] == BANK_FILLING);
  end

  // Control and output-stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_st_r[0] <= BANK_FREE;
      bank_st_r[1] <= BANK_FREE;
      wr_sel_r     <= 1'b0;
      rd_sel_r     <= 1'b0;
      wr_cnt_r     <= CNT_ZERO;
      rd_cnt_r     <= CNT_ZERO;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_data_r   <= {W{1'b0}};
    end else begin
      bank_st_r    <= bank_st_nxt_s;
      wr_sel_r     <= wr_sel_nxt_s;
      rd_sel_r     <= rd_sel_nxt_s;
      wr_cnt_r     <= wr_cnt_nxt_s;
      rd_cnt_r     <= rd_cnt_nxt_s;
      in_ready_r   <= in_ready_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      out_last_r   <= out_last_nxt_s;
      out_data_r   <= out_data_nxt_s;
    end
  end

  // Bank memory write port; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && wr_fire_s) begin
      mem_r[{wr_sel_r, wr_cnt_r}] <= in_data;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Directed self-checking bench for ntt_bitrev_reorder (W=32, N=16) with a frame scoreboard.
module tb_ntt_bitrev_reorder;

  localparam int W = 32;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fcnt = 0;
  int acc_edge = 0;
  int ov_edge = 0;
  int bubbles = 0;
  bit ov_seen = 1'b0;
  bit started = 1'b0;
  int perm [N];
  logic [31:0] fbuf [N];
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  ntt_bitrev_reorder #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    logic [32:0] e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      fbuf[fcnt] = in_data;
      fcnt++;
      if (fcnt == N) begin
        for (int k = 0; k < N; k++) exp_q.push_back({k == N-1, fbuf[perm[k]]});
        fcnt = 0;
        acc_edge = cyc + 1;
      end
    end
    if (out_valid && !ov_seen) begin
      ov_seen = 1'b1;
      ov_edge = cyc;
    end
    if (out_valid) started = 1'b1;
    if (out_valid && out_ready) begin
      chk("out_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[31:0]);
        chk("out_last", {31'd0, out_last}, {31'd0, e[32]});
      end
    end else if (!out_valid && out_ready && started && exp_q.size() != 0) begin
      bubbles++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    cycle();
    cycle();
    exp_q.delete();
    fcnt = 0;
    ov_seen = 1'b0;
    started = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input int base, input int n);
    bit acc;
    bit stalled;
    int g;
    stalled = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + i;
      acc = 1'b0;
      g = 0;
      while (!acc && g < 100) begin
        acc = in_ready;
        cycle();
        g++;
      end
      if (!acc) stalled = 1'b1;
    end
    in_valid = 1'b0;
    chk("send_stall", {31'd0, stalled}, 32'd0);
  endtask

  task automatic drain(input int maxc);
    int g;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < maxc) begin
      cycle();
      g++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    bit lx, pr, done, acc;
    int g, sent;
`ifdef NTT_REORDER_BITREV_EN
    perm = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
    for (int k = 0; k < N; k++) perm[k] = k;
`endif
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 32'd0;
    out_ready = 1'b0;
    do_reset();

    // Single frame 0..15 with out_ready high: order, out_last, two-edge latency.
    out_ready = 1'b1;
    send(0, N);
    drain(100);
    chk("latency", ov_edge - acc_edge, 32'd2);

    // Three frames offered back-to-back: output stream must stay contiguous.
    started = 1'b0;
    bubbles = 0;
    send(0, N);
    send(100, N);
    send(200, N);
    drain(100);
    chk("bubbles", bubbles, 32'd0);

    // Two frames with out_ready low: both banks occupied, output held, then ordered drain.
    out_ready = 1'b0;
    send(0, N);
    send(20, N);
    chk("ready_low", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'd999;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", out_data, 32'd0);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    done = 1'b0;
    g = 0;
    while (!done && g < 40) begin
      lx = out_valid && out_ready && out_last;
      pr = in_ready;
      cycle();
      g++;
      if (lx) begin
        chk("ready_in_last", {31'd0, pr}, 32'd0);
        chk("ready_after_last", {31'd0, in_ready}, 32'd1);
        done = 1'b1;
      end
    end
    chk("last_seen", {31'd0, done}, 32'd1);
    drain(100);

    // Reset after a partial frame; only the following frame may appear.
    out_ready = 1'b1;
    send(0, 7);
    do_reset();
    out_ready = 1'b1;
    send(50, N);
    drain(100);

    // Randomly throttled input and output over twenty frames.
    sent = 0;
    g = 0;
    while (sent < 20*N && g < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 1000 + sent;
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      cycle();
      if (acc) sent++;
      g++;
    end
    chk("rand_sent", sent, 20*N);
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
